// File: rtl/mt_sequencer_if.sv
// Execute <-> sequencer timing interface.
// Execute drives advance requests; the sequencer returns the M/T vector.
interface mt_sequencer_if;
    logic nextM;
    logic setM1;
    logic setM1cc;
    logic setM1bz;
    logic cond_true;
    logic b_zero;
    logic hold_clk_wait;
    logic M1, M2, M3, M4, M5, M6;
    logic T1, T2, T3, T4, T5, T6;
    logic seq_err;

    modport master (
        output nextM, setM1, setM1cc, setM1bz,
        output cond_true, b_zero, hold_clk_wait,
        input  M1, M2, M3, M4, M5, M6,
        input  T1, T2, T3, T4, T5, T6,
        input  seq_err
    );

    modport slave (
        input  nextM, setM1, setM1cc, setM1bz,
        input  cond_true, b_zero, hold_clk_wait,
        output M1, M2, M3, M4, M5, M6,
        output T1, T2, T3, T4, T5, T6,
        output seq_err
    );
endinterface

// File: rtl/mt_sequencer.sv
// Machine-cycle / T-state sequencer feeding execute.
// All outputs come straight from flops; wait watchdog raises a sticky error.
module mt_sequencer #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned WCNT_W     = 8
) (
    input  logic          clk,
    input  logic          nreset,
    mt_sequencer_if.slave bus
);

    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
    localparam logic [5:0]        ONE_1    = 6'b000001;

    logic [5:0]        m_q, m_d;
    logic [5:0]        t_q, t_d;
    logic              err_q, err_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic go_m1;
    logic go_next;

    // Resolve the conditional end-of-instruction requests.
    always_comb begin
        go_m1 = bus.setM1
              | (bus.setM1cc & bus.cond_true)
              | (bus.setM1bz & bus.b_zero);
        go_next = bus.nextM & ~go_m1;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            m_q    <= ONE_1;
            t_q    <= ONE_1;
            err_q  <= 1'b0;
            wcnt_q <= '0;
        end else begin
            m_q    <= m_d;
            t_q    <= t_d;
            err_q  <= err_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Next-state: wait freeze, then M1 restart, then next M, else T advance.
    always_comb begin
        m_d    = m_q;
        t_d    = t_q;
        err_d  = err_q;
        wcnt_d = '0;
        if (bus.hold_clk_wait) begin
            wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
            // Watchdog only flags; the freeze itself is never broken here.
            if (WAIT_LIMIT != 0 && 32'(wcnt_d) >= WAIT_LIMIT) begin
                err_d = 1'b1;
            end
        end else if (go_m1) begin
            m_d = ONE_1;
            t_d = ONE_1;
        end else if (go_next) begin
            t_d = ONE_1;
            if (m_q[5]) begin
                m_d   = ONE_1;
                err_d = 1'b1;
            end else begin
                m_d = m_q << 1;
            end
        end else if (t_q[5]) begin
            // Running off the end of T6 means execute lost track.
            m_d   = ONE_1;
            t_d   = ONE_1;
            err_d = 1'b1;
        end else begin
            t_d = t_q << 1;
        end
    end

    // Outputs are direct flop copies so execute sees a stable vector.
    always_comb begin
        bus.M1      = m_q[0];
        bus.M2      = m_q[1];
        bus.M3      = m_q[2];
        bus.M4      = m_q[3];
        bus.M5      = m_q[4];
        bus.M6      = m_q[5];
        bus.T1      = t_q[0];
        bus.T2      = t_q[1];
        bus.T3      = t_q[2];
        bus.T4      = t_q[3];
        bus.T5      = t_q[4];
        bus.T6      = t_q[5];
        bus.seq_err = err_q;
    end

endmodule
